// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word per instruction, holds it for decode.
// Latency: request in the cycle after reset or accept; instruction valid the cycle after rvalid; 3-cycle minimum loop.
// Backpressure: holds instruction/pc_current stable and issues no request until instr_ready; REQ waits on imem_ready.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   imem_req/imem_addr/imem_ready  fetch request handshake (addr = fetch_pc in every state)
//   imem_rvalid/imem_rdata       fetch response, sampled only while waiting for it
//   instruction/pc_current/instr_valid/instr_ready  held instruction to decode
//   pc_new                       next PC from branch logic, sampled only on accept
//   halted, fetch_err, instr_count  status: halt retired, sticky timeout, saturating retire count
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction,
    output logic [15:0] pc_current,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [15:0] pc_new,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // wait_cnt counts completed silent WAIT cycles; the last allowed one triggers reissue.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] fetch_pc;
    logic [7:0]  wait_cnt;
    logic        is_halt_op;

    assign is_halt_op = (instruction[15:12] == 4'hF);
    assign imem_addr  = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs; no input reaches an output combinationally.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response on the timeout cycle is still taken.
                if (imem_rvalid) begin
                    state_nxt = ST_HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = is_halt_op ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            wait_cnt    <= 8'd0;
            instruction <= 16'h0000;
            pc_current  <= 16'h0000;
            fetch_err   <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ready) begin
                        wait_cnt <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instruction <= imem_rdata;
                        pc_current  <= fetch_pc;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        if (instr_count != 16'hFFFF) begin
                            instr_count <= instr_count + 16'd1;
                        end
                        // Instructions are word aligned: bit 0 of the branch target is dropped.
                        if (!is_halt_op) begin
                            fetch_pc <= pc_new & 16'hFFFE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences, randomized transactions.
// Expected values come from a transaction-level model (next PC, saturating count, sticky error, halt).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;

    localparam int          TO       = 16;
    localparam logic [15:0] RST_PC   = 16'h0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic [15:0] pc_current;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_new;
    logic        halted;
    logic        fetch_err;
    logic [15:0] instr_count;

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_current  (pc_current),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_new      (pc_new),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level reference state
    logic [15:0] exp_pc;
    logic [15:0] exp_cnt;
    logic        exp_err;

    typedef struct {
        logic [15:0] exp_addr;
        logic [15:0] rdata;
        logic [15:0] pnew;
        int          rdy;
        int          rsp;
        int          hold;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_pc  = RST_PC;
        exp_cnt = 16'h0000;
        exp_err = 1'b0;
        chk("rst_req",   16'(imem_req), 16'd1);
        chk("rst_addr",  imem_addr, RST_PC);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_pc",    pc_current, 16'h0000);
        chk("rst_halt",  16'(halted), 16'd0);
        chk("rst_err",   16'(fetch_err), 16'd0);
        chk("rst_cnt",   instr_count, 16'h0000);
    endtask

    // One instruction fetch, optionally preceded by n_to timed-out attempts.
    // rsp_dly = silent WAIT cycles before rvalid (TO-1 puts rvalid on the last WAIT cycle).
    task automatic fetch_one(input logic [15:0] rdata, input logic [15:0] pnew,
                             input int rdy_dly, input int rsp_dly, input int hold_dly,
                             input int n_to, input bit preset);
        logic [15:0] a;
        a = exp_pc;
        for (int t = 0; t < n_to; t++) begin
            chk("to_req",  16'(imem_req), 16'd1);
            chk("to_addr", imem_addr, a);
            imem_ready = 1'b1;
            tick();
            imem_ready = 1'b0;
            for (int c = 0; c < TO; c++) begin
                chk("to_wait_req", 16'(imem_req), 16'd0);
                tick();
            end
            exp_err = 1'b1;
            chk("to_reissue", 16'(imem_req), 16'd1);
            chk("to_err", 16'(fetch_err), 16'(exp_err));
        end
        chk("req",   16'(imem_req), 16'd1);
        chk("addr",  imem_addr, a);
        chk("valid_idle", 16'(instr_valid), 16'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            imem_ready = 1'b0;
            tick();
            chk("req_held",  16'(imem_req), 16'd1);
            chk("addr_held", imem_addr, a);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            chk("wait_req",   16'(imem_req), 16'd0);
            chk("wait_valid", 16'(instr_valid), 16'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = rdata;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        chk("hold_valid", 16'(instr_valid), 16'd1);
        chk("hold_instr", instruction, rdata);
        chk("hold_pc",    pc_current, a);
        chk("hold_err",   16'(fetch_err), 16'(exp_err));
        for (int i = 0; i < hold_dly; i++) begin
            instr_ready = 1'b0;
            pc_new      = 16'($urandom);
            imem_rvalid = 1'($urandom);
            imem_rdata  = 16'($urandom);
            tick();
            chk("stall_valid", 16'(instr_valid), 16'd1);
            chk("stall_instr", instruction, rdata);
            chk("stall_pc",    pc_current, a);
            chk("stall_req",   16'(imem_req), 16'd0);
        end
        imem_rvalid = 1'b0;
        if (preset) begin
            force dut.instr_count = 16'hFFFE;
            #1;
            release dut.instr_count;
            exp_cnt = 16'hFFFE;
            chk("cnt_preset", instr_count, exp_cnt);
        end
        instr_ready = 1'b1;
        pc_new      = pnew;
        tick();
        instr_ready = 1'b0;
        pc_new      = 16'($urandom);
        exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
        chk("cnt", instr_count, exp_cnt);
        chk("valid_drop", 16'(instr_valid), 16'd0);
        if (rdata[15:12] == 4'hF) begin
            chk("halt",      16'(halted), 16'd1);
            chk("halt_req",  16'(imem_req), 16'd0);
        end else begin
            exp_pc = {pnew[15:1], 1'b0};
            chk("no_halt",   16'(halted), 16'd0);
            chk("next_req",  16'(imem_req), 16'd1);
            chk("next_addr", imem_addr, exp_pc);
        end
    endtask

    initial begin
        rst         = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        pc_new      = 16'h0000;
        exp_pc      = RST_PC;
        exp_cnt     = 16'h0000;
        exp_err     = 1'b0;

        //            exp_addr  rdata     pc_new    rdy rsp   hold exp_next
        vecs[0] = '{16'h0000, 16'h1234, 16'h0002, 0, 0,    0, 16'h0002};
        vecs[1] = '{16'h0002, 16'h2ABC, 16'h0041, 0, 0,    5, 16'h0040};
        vecs[2] = '{16'h0040, 16'h3001, 16'hFFFF, 4, 0,    0, 16'hFFFE};
        vecs[3] = '{16'hFFFE, 16'h4555, 16'h1000, 0, TO-1, 0, 16'h1000};
        vecs[4] = '{16'h1000, 16'hE00F, 16'h8001, 2, 3,    2, 16'h8000};

        tick();
        do_reset();

        for (int v = 0; v < 5; v++) begin
            chk("vec_addr", imem_addr, vecs[v].exp_addr);
            fetch_one(vecs[v].rdata, vecs[v].pnew, vecs[v].rdy, vecs[v].rsp, vecs[v].hold, 0, 1'b0);
            chk("vec_next", imem_addr, vecs[v].exp_next);
            chk("vec_noerr", 16'(fetch_err), 16'd0);
        end

        // Timeout: reissue at the same address, error sticks across a later good fetch.
        fetch_one(16'h0777, 16'h0100, 0, 1, 0, 1, 1'b0);
        chk("err_sticky", 16'(fetch_err), 16'd1);

        // Reset while waiting; the late response shows up in REQ and must be ignored.
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        rst         = 1'b1;
        tick();
        rst         = 1'b0;
        exp_pc      = RST_PC;
        exp_cnt     = 16'h0000;
        exp_err     = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBEEF;
        chk("mid_rst_req", 16'(imem_req), 16'd1);
        tick();
        chk("stale_req",   16'(imem_req), 16'd1);
        chk("stale_valid", 16'(instr_valid), 16'd0);
        tick();
        imem_rvalid = 1'b0;
        chk("stale_instr", instruction, 16'h0000);
        fetch_one(16'h5555, 16'h0200, 0, 0, 0, 0, 1'b0);

        // Count saturation
        fetch_one(16'h6001, 16'h0300, 0, 0, 1, 0, 1'b1);
        fetch_one(16'h6002, 16'h0400, 0, 0, 0, 0, 1'b0);
        chk("cnt_sat", instr_count, 16'hFFFF);

        // Halt: fetch stays frozen, then reset restarts at RESET_PC.
        fetch_one(16'hF000, 16'h1234, 0, 0, 1, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            imem_ready  = 1'b1;
            imem_rvalid = 1'b1;
            instr_ready = 1'b1;
            tick();
            chk("halt_noreq",  16'(imem_req), 16'd0);
            chk("halt_hold",   16'(halted), 16'd1);
            chk("halt_valid",  16'(instr_valid), 16'd0);
        end
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        chk("halt_instr", instruction, 16'hF000);
        chk("halt_pc",    pc_current, 16'h0400);
        do_reset();

        // Randomized transactions against the model
        for (int i = 0; i < 150; i++) begin
            logic [15:0] rd;
            rd = {4'($urandom_range(0, 14)), 12'($urandom)};
            fetch_one(rd, 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 1 : 0, (i == 140));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
